// File: rtl/systolic_array_os_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_os_if
// Description : Job/stream bundle for the output-stationary systolic array.
//               master = job issuer (drives start/k_len and the operand beats)
//               slave  = systolic_array_os
//   start    : one-cycle job request (honoured only when the array is idle)
//   k_len    : inner dimension K of the job, sampled with start
//   in_valid : a_col/b_row carry one beat k
//   in_ready : the array is accepting beats
//   a_col    : column k of A, lane i = A[i][k]
//   b_row    : row k of B, lane j = B[k][j]
//   busy     : a job is in progress
//   done     : one-cycle pulse when c_out becomes valid
//   c_out    : result grid, element (i,j) at bits (i*N+j)*AW +: AW
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_array_os_if #(
  parameter int N  = 2,
  parameter int DW = 8,
  parameter int AW = 20,
  parameter int KW = 5
);
  logic              start;
  logic [KW-1:0]     k_len;
  logic              in_valid;
  logic              in_ready;
  logic [N*DW-1:0]   a_col;
  logic [N*DW-1:0]   b_row;
  logic              busy;
  logic              done;
  logic [N*N*AW-1:0] c_out;

  modport master (
    output start, k_len, in_valid, a_col, b_row,
    input  in_ready, busy, done, c_out
  );

  modport slave (
    input  start, k_len, in_valid, a_col, b_row,
    output in_ready, busy, done, c_out
  );
endinterface
`default_nettype wire

// File: rtl/systolic_array_os.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_os
// Description : NxN output-stationary systolic array computing C = A x B.
//               A columns stream in from the left, B rows from the top, each
//               lane skewed by its index so that A[i][k] and B[k][j] meet in
//               PE(i,j). Every PE accumulates in place; c_out exposes the
//               accumulators directly.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous, active-high reset
//               bus  - systolic_array_os_if.slave (job, beat stream, results)
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_array_os #(
  parameter int N  = 2,
  parameter int DW = 8,
  parameter int AW = 20,
  parameter int KW = 5
) (
  input  logic               clk,
  input  logic               rst,
  systolic_array_os_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Drain runs 2N-1 cycles: the last beat needs 2N-2 hops to reach PE(N-1,N-1).
  localparam int              DCW       = $clog2(2 * N);
  localparam logic [DCW-1:0]  DRAIN_END = DCW'(2 * N - 2);

  logic [1:0]     state_q, state_d;
  logic [KW-1:0]  klen_q;
  logic [KW-1:0]  beat_q;
  logic [DCW-1:0] drain_q;

  logic accept_w;   // a beat is consumed this cycle
  logic advance_w;  // the whole array shifts/accumulates this cycle
  logic clear_w;    // a new job is accepted: wipe the datapath

  assign accept_w  = bus.in_valid && (state_q == S_LOAD);
  assign advance_w = accept_w || (state_q == S_DRAIN);
  assign clear_w   = (state_q == S_IDLE) && bus.start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = (bus.k_len == '0) ? S_DONE : S_LOAD;
      S_LOAD:  if (accept_w && (beat_q == klen_q - 1'b1)) state_d = S_DRAIN;
      S_DRAIN: if (drain_q == DRAIN_END) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      klen_q  <= '0;
      beat_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      if (clear_w) begin
        klen_q <= bus.k_len;
        beat_q <= '0;
      end else if (accept_w) begin
        beat_q <= beat_q + 1'b1;
      end
      drain_q <= (state_q == S_DRAIN) ? drain_q + 1'b1 : '0;
    end
  end

  assign bus.in_ready = (state_q == S_LOAD);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);

  // a_pass[i][j] / b_pass[i][j]: operands presented to PE(i,j).
  logic [DW-1:0]     a_pass [N][N];
  logic [DW-1:0]     b_pass [N][N];
  logic [N*N*AW-1:0] c_w;

  genvar gi, gj;

  // Input skew: lane i is delayed i stages. Outside LOAD zeros are injected,
  // which is what the drain phase shifts in.
  for (gi = 0; gi < N; gi++) begin : g_skew
    logic [DW-1:0] a_lane_w, b_lane_w;
    assign a_lane_w = (state_q == S_LOAD) ? bus.a_col[gi*DW +: DW] : '0;
    assign b_lane_w = (state_q == S_LOAD) ? bus.b_row[gi*DW +: DW] : '0;

    if (gi == 0) begin : g_direct
      assign a_pass[0][0] = a_lane_w;
      assign b_pass[0][0] = b_lane_w;
    end else begin : g_delay
      logic [DW-1:0] a_sr_q [gi];
      logic [DW-1:0] b_sr_q [gi];
      always_ff @(posedge clk) begin
        if (rst || clear_w) begin
          for (int s = 0; s < gi; s++) begin
            a_sr_q[s] <= '0;
            b_sr_q[s] <= '0;
          end
        end else if (advance_w) begin
          a_sr_q[0] <= a_lane_w;
          b_sr_q[0] <= b_lane_w;
          for (int s = 1; s < gi; s++) begin
            a_sr_q[s] <= a_sr_q[s-1];
            b_sr_q[s] <= b_sr_q[s-1];
          end
        end
      end
      assign a_pass[gi][0] = a_sr_q[gi-1];
      assign b_pass[0][gi] = b_sr_q[gi-1];
    end
  end

  for (gi = 0; gi < N; gi++) begin : g_row
    for (gj = 0; gj < N; gj++) begin : g_col
      logic signed [2*DW-1:0] a_x_w, b_x_w, prod_w;
      logic        [AW-1:0]   acc_q;

      assign a_x_w  = (2*DW)'($signed(a_pass[gi][gj]));
      assign b_x_w  = (2*DW)'($signed(b_pass[gi][gj]));
      assign prod_w = a_x_w * b_x_w;

      // AW'() sign-extends the product when AW > 2*DW and truncates it
      // otherwise; either way the sum wraps modulo 2^AW.
      always_ff @(posedge clk) begin
        if (rst || clear_w) acc_q <= '0;
        else if (advance_w)  acc_q <= acc_q + AW'(prod_w);
      end

      if (gj < N - 1) begin : g_fwd_a
        logic [DW-1:0] a_q;
        always_ff @(posedge clk) begin
          if (rst || clear_w) a_q <= '0;
          else if (advance_w)  a_q <= a_pass[gi][gj];
        end
        assign a_pass[gi][gj+1] = a_q;
      end

      if (gi < N - 1) begin : g_fwd_b
        logic [DW-1:0] b_q;
        always_ff @(posedge clk) begin
          if (rst || clear_w) b_q <= '0;
          else if (advance_w)  b_q <= b_pass[gi][gj];
        end
        assign b_pass[gi+1][gj] = b_q;
      end

      assign c_w[(gi*N+gj)*AW +: AW] = acc_q;
    end
  end

  assign bus.c_out = c_w;

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_os.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_array_os
// Description : Self-checking bench. Three arrays share one stimulus stream:
//               N=2/AW=20, N=2/AW=14 and N=4/AW=20 (the N=2 results are the
//               top-left corner of the N=4 product). Table vectors hold the
//               hand-computed corner cases; random jobs are checked against a
//               plain matrix-product model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_array_os;

  logic        clk = 1'b0;
  logic        rst;
  logic        st;
  logic [4:0]  kl;
  logic        iv;
  logic [31:0] ac, br;

  always #5 clk = ~clk;

  systolic_array_os_if #(.N(2), .DW(8), .AW(20), .KW(5)) bus2 ();
  systolic_array_os_if #(.N(2), .DW(8), .AW(14), .KW(5)) bus2w ();
  systolic_array_os_if #(.N(4), .DW(8), .AW(20), .KW(5)) bus4 ();

  assign bus2.start  = st;  assign bus2.k_len  = kl;  assign bus2.in_valid  = iv;
  assign bus2.a_col  = ac[15:0];  assign bus2.b_row  = br[15:0];
  assign bus2w.start = st;  assign bus2w.k_len = kl;  assign bus2w.in_valid = iv;
  assign bus2w.a_col = ac[15:0];  assign bus2w.b_row = br[15:0];
  assign bus4.start  = st;  assign bus4.k_len  = kl;  assign bus4.in_valid  = iv;
  assign bus4.a_col  = ac;  assign bus4.b_row  = br;

  systolic_array_os #(.N(2), .DW(8), .AW(20), .KW(5)) u_dut2  (.clk(clk), .rst(rst), .bus(bus2));
  systolic_array_os #(.N(2), .DW(8), .AW(14), .KW(5)) u_dut2w (.clk(clk), .rst(rst), .bus(bus2w));
  systolic_array_os #(.N(4), .DW(8), .AW(20), .KW(5)) u_dut4  (.clk(clk), .rst(rst), .bus(bus4));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference operands: ma[i][k] = A[i][k], mb[k][j] = B[k][j].
  int ma [4][32];
  int mb [32][4];

  typedef struct {
    int k, gap, poke;
    int a00, a01, a10, a11;   // A[i][k]
    int b00, b01, b10, b11;   // B[k][j]
    int e00, e01, e10, e11;   // expected C, AW=20
    int ew00;                 // expected C(0,0), AW=14
    int lat;                  // expected start-to-done latency, N=2
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int wrap(input int v, input int aw);
    int t;
    t = v <<< (32 - aw);
    return t >>> (32 - aw);
  endfunction

  function automatic int ref_c(input int i, input int j, input int k);
    int s = 0;
    for (int p = 0; p < k; p++) s += ma[i][p] * mb[p][j];
    return s;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 4; i++)
      for (int p = 0; p < 32; p++) begin
        ma[i][p] = int'($urandom_range(0, 255)) - 128;
        mb[p][i] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  task automatic load_entry(input int t);
    fill_random();
    ma[0][0] = tbl[t].a00;  ma[0][1] = tbl[t].a01;
    ma[1][0] = tbl[t].a10;  ma[1][1] = tbl[t].a11;
    mb[0][0] = tbl[t].b00;  mb[0][1] = tbl[t].b01;
    mb[1][0] = tbl[t].b10;  mb[1][1] = tbl[t].b11;
  endtask

  // Issues one job (start in cycle 1), streams K beats with `gap` bubble
  // cycles between beats, optionally re-pulses start (k_len=0) at cycle `poke`,
  // and reports the cycle index of each array's first done and done counts.
  task automatic run_job(input int k, input int gap, input int poke,
                         output int lat2, output int lat4,
                         output int nd2, output int nd4, output int ndw);
    int  cyc, beat, gl;
    bit  acc;
    lat2 = 0; lat4 = 0; nd2 = 0; nd4 = 0; ndw = 0; beat = 0; gl = 0;
    @(posedge clk); #1;
    st = 1'b1; kl = 5'(k); iv = 1'b0; cyc = 1;
    while ((lat2 == 0 || lat4 == 0) && cyc < 300) begin
      acc = iv && bus4.in_ready;
      @(posedge clk); #1;
      cyc++;
      st = (cyc == poke);
      if (cyc == poke) kl = 5'd0;
      if (acc) begin beat++; gl = gap; end
      if (bus2.done)  begin nd2++; if (lat2 == 0) lat2 = cyc; end
      if (bus4.done)  begin nd4++; if (lat4 == 0) lat4 = cyc; end
      if (bus2w.done) ndw++;
      if (bus4.in_ready && beat < k && gl == 0) begin
        iv = 1'b1;
        for (int i = 0; i < 4; i++) begin
          ac[i*8 +: 8] = 8'(ma[i][beat]);
          br[i*8 +: 8] = 8'(mb[beat][i]);
        end
      end else begin
        iv = bus4.in_ready ? 1'b0 : 1'($urandom_range(0, 1));
        ac = $urandom; br = $urandom;
        if (bus4.in_ready && gl > 0) gl--;
      end
    end
    st = 1'b0; iv = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus2.done)  nd2++;
      if (bus4.done)  nd4++;
      if (bus2w.done) ndw++;
    end
  endtask

  task automatic check_model(input int k, input string tag);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("%s c4[%0d][%0d]", tag, i, j),
            int'($signed(bus4.c_out[(i*4+j)*20 +: 20])), wrap(ref_c(i, j, k), 20));
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        chk($sformatf("%s c2[%0d][%0d]", tag, i, j),
            int'($signed(bus2.c_out[(i*2+j)*20 +: 20])), wrap(ref_c(i, j, k), 20));
        chk($sformatf("%s c2w[%0d][%0d]", tag, i, j),
            int'($signed(bus2w.c_out[(i*2+j)*14 +: 14])), wrap(ref_c(i, j, k), 14));
      end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, " busy"},     int'(bus2.busy | bus4.busy | bus2w.busy), 0);
    chk({tag, " in_ready"}, int'(bus2.in_ready | bus4.in_ready | bus2w.in_ready), 0);
    chk({tag, " done"},     int'(bus2.done | bus4.done | bus2w.done), 0);
    chk({tag, " c_out"},    int'((|bus2.c_out) | (|bus4.c_out) | (|bus2w.c_out)), 0);
  endtask

  initial begin
    int l2, l4, n2, n4, nw, k, gap, dn;

    tbl[0] = '{2, 0, 0,    1, 2, 3, 4,       5, 6, 7, 8,       19, 22, 43, 50,            19, 7};
    tbl[1] = '{1, 0, 0, -128, 0, 127, 0,  -128, 127, 0, 0,  16384, -16256, -16256, 16129, 0, 6};
    tbl[2] = '{2, 3, 0,    1, 2, 3, 4,       5, 6, 7, 8,       19, 22, 43, 50,            19, 10};
    tbl[3] = '{0, 0, 0,    0, 0, 0, 0,       0, 0, 0, 0,        0,  0,  0,  0,             0, 2};
    tbl[4] = '{2, 0, 5,    1, 2, 3, 4,       5, 6, 7, 8,       19, 22, 43, 50,            19, 7};

    rst = 1'b1; st = 1'b0; kl = '0; iv = 1'b0; ac = '0; br = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst = 1'b0;

    for (int t = 0; t < 5; t++) begin
      load_entry(t);
      run_job(tbl[t].k, tbl[t].gap, tbl[t].poke, l2, l4, n2, n4, nw);
      chk($sformatf("vec%0d lat2", t), l2, tbl[t].lat);
      chk($sformatf("vec%0d lat4", t), l4, tbl[t].lat + ((tbl[t].k > 0) ? 4 : 0));
      chk($sformatf("vec%0d ndone2", t), n2, 1);
      chk($sformatf("vec%0d ndone4", t), n4, 1);
      chk($sformatf("vec%0d ndonew", t), nw, 1);
      chk($sformatf("vec%0d c00", t), int'($signed(bus2.c_out[0  +: 20])), tbl[t].e00);
      chk($sformatf("vec%0d c01", t), int'($signed(bus2.c_out[20 +: 20])), tbl[t].e01);
      chk($sformatf("vec%0d c10", t), int'($signed(bus2.c_out[40 +: 20])), tbl[t].e10);
      chk($sformatf("vec%0d c11", t), int'($signed(bus2.c_out[60 +: 20])), tbl[t].e11);
      chk($sformatf("vec%0d cw00", t), int'($signed(bus2w.c_out[0 +: 14])), tbl[t].ew00);
      check_model(tbl[t].k, $sformatf("vec%0d", t));
    end

    // Random jobs; the first is the full-depth N=4 scale case.
    for (int r = 0; r < 4; r++) begin
      fill_random();
      k   = (r == 0) ? 31 : int'($urandom_range(1, 31));
      gap = (r == 0) ? 0  : int'($urandom_range(0, 2));
      run_job(k, gap, 0, l2, l4, n2, n4, nw);
      chk($sformatf("rnd%0d lat2", r), l2, k + 5 + gap * (k - 1));
      chk($sformatf("rnd%0d lat4", r), l4, k + 9 + gap * (k - 1));
      chk($sformatf("rnd%0d ndone4", r), n4, 1);
      check_model(k, $sformatf("rnd%0d", r));
    end

    // Reset mid-job: rst coincides with the first beat of a K=2 job.
    load_entry(0);
    @(posedge clk); #1;
    st = 1'b1; kl = 5'd2;
    @(posedge clk); #1;
    st = 1'b0;
    iv = 1'b1; ac = 32'h0000_0301; br = 32'h0000_0605; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; iv = 1'b0;
    check_idle_zero("midrst");
    // rst must also win over a simultaneous start.
    st = 1'b1; kl = 5'd2; rst = 1'b1;
    @(posedge clk); #1;
    st = 1'b0; rst = 1'b0;
    chk("rst_vs_start busy", int'(bus2.busy | bus4.busy), 0);
    dn = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus2.done || bus4.done || bus2w.done) dn++;
    end
    chk("midrst no done", dn, 0);
    run_job(2, 0, 0, l2, l4, n2, n4, nw);
    chk("post_rst lat2", l2, 7);
    chk("post_rst ndone2", n2, 1);
    chk("post_rst c00", int'($signed(bus2.c_out[0  +: 20])), 19);
    chk("post_rst c11", int'($signed(bus2.c_out[60 +: 20])), 50);
    check_model(2, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_array_os.md
SYSTOLIC_ARRAY_OS -- requirements
Module: systolic_array_os

Interface
REQ-001 Parameter N, default 2: array dimension, giving an NxN grid of PEs; legal range 2..8.
REQ-002 Parameter DW, default 8: operand width, signed two's complement.
REQ-003 Parameter AW, default 20: accumulator and result width, signed.
REQ-004 Parameter KW, default 5: width of k_len; maximum depth is 2^KW-1.
REQ-005 Port clk, input, 1: the block has one clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1: reset is synchronous and active-high.
REQ-007 Port start, input, 1: one-cycle request to begin a C=AxB job; sampled only in IDLE.
REQ-008 Port k_len, input, KW: inner dimension K; sampled with start.
REQ-009 Port in_valid, input, 1: a_col and b_row hold one beat k.
REQ-010 Port in_ready, output, 1: high only in LOAD.
REQ-011 Port a_col, input, N*DW: column k of A; lane i (bits i*DW+:DW) is A[i][k].
REQ-012 Port b_row, input, N*DW: row k of B; lane j is B[k][j].
REQ-013 Port busy, output, 1: high in every state except IDLE.
REQ-014 Port done, output, 1: one-cycle pulse when c_out becomes valid.
REQ-015 Port c_out, output, N*N*AW: result grid; element (i,j) is at bits (i*N+j)*AW+:AW.

Function
REQ-016 FSM states and transitions:
- IDLE -> LOAD on start with k_len>0.
- IDLE -> DONE on start with k_len==0.
- LOAD -> DRAIN on the k_len-th accepted beat.
- DRAIN -> DONE after exactly 2N-1 cycles.
- DONE -> IDLE unconditionally.
REQ-017 A beat is accepted when in_valid && in_ready; the beat counter increments by 1 per accepted beat.
REQ-018 Input skew: lane i of a_col passes through i register stages before entering PE row i. Lane j of b_row passes through j stages before entering PE column j.
REQ-019 Dataflow: each PE(i,j) registers its A operand toward PE(i,j+1) and its B operand toward PE(i+1,j).
REQ-020 MAC: each PE(i,j) computes acc <= acc + sext(a*b). The product is 2*DW bits signed, sign-extended to AW; the sum wraps modulo 2^AW with no saturation.
REQ-021 Stall in LOAD: when in_valid is low, all skew registers, PE operand registers and accumulators hold their values. The result is independent of bubble placement.
REQ-022 Drain: in DRAIN the array advances every cycle with zeros injected on all lanes.
REQ-023 Job start: on the IDLE->LOAD or IDLE->DONE transition, all accumulators and skew/operand registers clear to 0.
REQ-024 c_out reflects the accumulators.
- It is valid from the done cycle until the next accepted start.
- It holds unchanged through IDLE.
REQ-025 done is high only in the DONE state, for exactly 1 cycle per job.
REQ-026 k_len==0 produces done 2 cycles after start, with c_out all-zero.
REQ-027 start while busy is ignored and does not affect the running job; in_valid outside LOAD is ignored.
REQ-028 Latency from start (k_len=K, no bubbles) to done is K+2N+1 cycles: 1 to enter LOAD, K beats, 2N-1 drain, 1 DONE.

Reset
REQ-029 On rst=1 at a clock edge:
- state <= IDLE;
- accumulators, skew and operand registers, and the beat counter <= 0;
- in_ready=0, busy=0, done=0, c_out=0.
REQ-030 rst asserted mid-job (LOAD or DRAIN) aborts the job with no done pulse. The next start after rst deasserts runs a clean job.
REQ-031 rst has priority over start and in_valid in the same cycle.

Verification
REQ-032 Basic case:
- Stimulus: N=2, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], no bubbles.
- Response: c_out=[[19,22],[43,50]]; done exactly 7 cycles after start.
REQ-033 Signed and wrap:
- Stimulus: N=2, K=1, A column=(-128,127), B row=(-128,127).
- Response: C=[[16384,-16256],[-16256,16129]].
- Also with AW=14: C(0,0) wraps to 0.
REQ-034 Bubbles:
- Stimulus: the REQ-032 job with in_valid low for 3 cycles between beats.
- Response: identical c_out; done delayed by exactly 3 cycles.
REQ-035 k_len=0 and busy start:
- Stimulus: k_len=0.
- Response: done after 2 cycles, c_out=0.
- Stimulus: start pulsed during DRAIN.
- Response: no second job; single done.
REQ-036 Reset mid-job:
- Stimulus: rst during LOAD beat 1, then the REQ-032 job.
- Response: no done during the aborted job; all outputs 0 after rst; the second job gives the correct C.
REQ-037 Scale case:
- Stimulus: N=4, K=31, random signed operands.
- Response: c_out matches the reference matrix product mod 2^AW; latency 31+9=40 cycles.
